// File: rtl/d_mux_pkg.sv
// Shared types and helpers for the 1:N stream demultiplexer.
package d_mux_pkg;

  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_t;

  // Select width: a 1-bit select is kept even for degenerate channel counts.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/d_mux_slot.sv
// One-entry holding register for a single output channel.
module d_mux_slot
  import d_mux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] data_in,
  input  logic         take,
  output logic         valid,
  output logic [W-1:0] data_out
);

  slot_state_t state;

  // load wins over take: a same-edge drain and refill leaves the slot full.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SLOT_EMPTY;
      data_out <= '0;
    end else if (load) begin
      state    <= SLOT_FULL;
      data_out <= data_in;
    end else if (take) begin
      state    <= SLOT_EMPTY;
    end
  end

  assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/d_mux_stream_n.sv
// 1:N demultiplexer with a one-entry slot per channel and valid/ready on both sides.
// Optional broadcast mode (in_bcast port) is enabled by defining D_MUX_BCAST_EN.
module d_mux_stream_n
  import d_mux_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = sel_w(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic [SW-1:0]  in_sel,
`ifdef D_MUX_BCAST_EN
  input  logic           in_bcast,
`endif
  output logic [N-1:0]   out_valid,
  input  logic [N-1:0]   out_ready,
  output logic [N*W-1:0] out_data,
  output logic           err
);

  logic [N-1:0] free;
  logic [N-1:0] hit;
  logic [N-1:0] load;
  logic         sel_ok;
  logic         uni_ready;
  logic         bcast;
  logic         accept;

`ifdef D_MUX_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  assign free = ~out_valid | out_ready;

  // Out-of-range selects match no channel, so they fall through as ready and unhit.
  always_comb begin
    hit       = '0;
    sel_ok    = 1'b0;
    uni_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (in_sel == SW'(i)) begin
        hit[i]    = 1'b1;
        sel_ok    = 1'b1;
        uni_ready = free[i];
      end
    end
  end

  assign in_ready = bcast ? (&free) : uni_ready;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst)
      err <= 1'b0;
    else if (accept & ~bcast & ~sel_ok)
      err <= 1'b1;
  end

  for (genvar i = 0; i < N; i++) begin : g_slot
    assign load[i] = accept & (bcast | hit[i]);

    d_mux_slot #(.W(W)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[i]),
      .data_in  (in_data),
      .take     (out_ready[i]),
      .valid    (out_valid[i]),
      .data_out (out_data[i*W +: W])
    );
  end

endmodule

// File: tb/tb_d_mux_stream_n.sv
// Randomized and directed checks of d_mux_stream_n against a slot-level reference model.
module tb_d_mux_stream_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // N=4 instance, covered by the reference model
  logic        iv4;
  logic [1:0]  sel4;
  logic [7:0]  dat4;
  logic [3:0]  ordy4;
  logic        ir4;
  logic [3:0]  ov4;
  logic [31:0] od4;
  logic        err4;
  logic        bc;

  // N=3 instance, used for out-of-range selects
  logic        iv3;
  logic [1:0]  sel3;
  logic [7:0]  dat3;
  logic [2:0]  ordy3;
  logic        ir3;
  logic [2:0]  ov3;
  logic [23:0] od3;
  logic        err3;

  d_mux_stream_n #(.N(4), .W(8)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_data(dat4), .in_sel(sel4),
`ifdef D_MUX_BCAST_EN
    .in_bcast(bc),
`endif
    .out_valid(ov4), .out_ready(ordy4), .out_data(od4), .err(err4)
  );

  d_mux_stream_n #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .in_data(dat3), .in_sel(sel3),
`ifdef D_MUX_BCAST_EN
    .in_bcast(1'b0),
`endif
    .out_valid(ov3), .out_ready(ordy3), .out_data(od3), .err(err3)
  );

  int total = 0;
  int bad   = 0;

  // Reference: each channel either holds a byte or not
  logic [3:0]  mv;
  logic [7:0]  md [4];
  logic        merr;

  function automatic logic [31:0] md_flat();
    return {md[3], md[2], md[1], md[0]};
  endfunction

  function automatic logic model_ready();
    logic r;
    if (bc) begin
      r = 1'b1;
      for (int i = 0; i < 4; i++) if (mv[i] && !ordy4[i]) r = 1'b0;
    end else begin
      r = !mv[sel4] || ordy4[sel4];
    end
    return r;
  endfunction

  // Advance one clock and the model with it; inputs must already be driven.
  task automatic tick();
    logic acc;
    #1;
    acc = iv4 && model_ready();
    if (rst) begin
      mv = '0; merr = 1'b0;
      for (int i = 0; i < 4; i++) md[i] = 8'h00;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (acc && (bc || int'(sel4) == i)) begin
          mv[i] = 1'b1; md[i] = dat4;
        end else if (ordy4[i]) begin
          mv[i] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic v, input int s, input logic [7:0] d);
    iv4 = v; sel4 = 2'(s); dat4 = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; iv4 = 0; sel4 = 0; dat4 = 0; ordy4 = 0; bc = 0;
    iv3 = 0; sel3 = 0; dat3 = 0; ordy3 = 0;
    tick(); tick();
    total++; if (ov4 !== 4'b0 || od4 !== 32'h0 || err4 !== 1'b0 || ir4 !== 1'b1) begin
      bad++; $display("FAIL reset_init ov=%h od=%h err=%b ir=%b want 0/0/0/1", ov4, od4, err4, ir4);
    end
    total++; if (ov3 !== 3'b0 || od3 !== 24'h0 || err3 !== 1'b0) begin
      bad++; $display("FAIL reset_init3 ov=%h od=%h err=%b want 0/0/0", ov3, od3, err3);
    end
    rst = 1'b0;
    // fill three slots, then reset mid-stream
    for (int i = 0; i < 3; i++) begin drive4(1, i, 8'(8'hB0 + i)); tick(); end
    total++; if (ov4 !== 4'b0111) begin
      bad++; $display("FAIL reset_fill ov=%b want 0111", ov4);
    end
    drive4(1, 3, 8'hEE); rst = 1'b1; tick();
    total++; if (ov4 !== 4'b0 || od4 !== 32'h0 || err4 !== 1'b0 || ir4 !== 1'b1) begin
      bad++; $display("FAIL reset_mid ov=%h od=%h err=%b ir=%b want 0/0/0/1", ov4, od4, err4, ir4);
    end
    rst = 1'b0; drive4(0, 0, 0);
  endtask

  task automatic test_steering();
    ordy4 = 4'hF;
    for (int i = 0; i < 4; i++) begin
      drive4(1, i, 8'(8'h11 * (i + 1)));
      #1;
      total++; if (ir4 !== 1'b1) begin bad++; $display("FAIL steer_ready%0d got=%b want=1", i, ir4); end
      tick();
      total++; if (ov4 !== 4'(1 << i) || od4[i*8 +: 8] !== 8'(8'h11 * (i + 1))) begin
        bad++; $display("FAIL steer_out%0d ov=%b od=%h want ov=%b byte=%h", i, ov4, od4, 4'(1 << i), 8'(8'h11 * (i + 1)));
      end
    end
    drive4(0, 0, 0); tick();
    total++; if (ov4 !== 4'b0 || od4 !== 32'h44332211) begin
      bad++; $display("FAIL steer_drain ov=%b od=%h want 0/44332211", ov4, od4);
    end
  endtask

  task automatic test_backpressure();
    ordy4 = 4'b1011;
    drive4(1, 2, 8'hA5); tick();
    drive4(1, 2, 8'h5A); #1;
    total++; if (ir4 !== 1'b0) begin bad++; $display("FAIL bp_stall got=%b want=0", ir4); end
    tick();
    total++; if (ov4[2] !== 1'b1 || od4[23:16] !== 8'hA5) begin
      bad++; $display("FAIL bp_hold v=%b d=%h want 1/a5", ov4[2], od4[23:16]);
    end
    ordy4[2] = 1'b1; #1;
    total++; if (ir4 !== 1'b1) begin bad++; $display("FAIL bp_release got=%b want=1", ir4); end
    tick();
    total++; if (ov4[2] !== 1'b1 || od4[23:16] !== 8'h5A) begin
      bad++; $display("FAIL bp_refill v=%b d=%h want 1/5a", ov4[2], od4[23:16]);
    end
    drive4(0, 0, 0); tick();
  endtask

  task automatic test_isolation();
    ordy4 = 4'b0000;
    drive4(1, 1, 8'h3C); tick();
    drive4(1, 0, 8'h01); #1;
    total++; if (ir4 !== 1'b1) begin bad++; $display("FAIL iso_ready0 got=%b want=1", ir4); end
    tick();
    drive4(1, 3, 8'h03); #1;
    total++; if (ir4 !== 1'b1) begin bad++; $display("FAIL iso_ready3 got=%b want=1", ir4); end
    tick();
    drive4(1, 1, 8'h99); #1;
    total++; if (ir4 !== 1'b0) begin bad++; $display("FAIL iso_block1 got=%b want=0", ir4); end
    tick();
    total++; if (ov4 !== 4'b1011 || od4[15:8] !== 8'h3C || od4[7:0] !== 8'h01 || od4[31:24] !== 8'h03) begin
      bad++; $display("FAIL iso_state ov=%b od=%h want 1011 with 03/../3c/01", ov4, od4);
    end
    ordy4 = 4'hF; drive4(0, 0, 0); tick();
  endtask

  task automatic test_random();
    int errs = 0;
    for (int n = 0; n < 300; n++) begin
      drive4($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), 8'($urandom));
      ordy4 = 4'($urandom);
      #1;
      total++; if (ir4 !== model_ready()) begin
        bad++; errs++; if (errs < 10) $display("FAIL rand_ready cyc=%0d got=%b want=%b", n, ir4, model_ready());
      end
      tick();
      total++; if (ov4 !== mv || od4 !== md_flat() || err4 !== merr) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rand_out cyc=%0d ov=%b od=%h err=%b want %b/%h/%b", n, ov4, od4, err4, mv, md_flat(), merr);
      end
    end
    drive4(0, 0, 0); ordy4 = 4'hF; tick();
  endtask

  task automatic test_bad_sel();
    ordy3 = 3'b000;
    iv3 = 1; sel3 = 2'd3; dat3 = 8'h77; #1;
    total++; if (ir3 !== 1'b1) begin bad++; $display("FAIL badsel_ready got=%b want=1", ir3); end
    tick();
    total++; if (ov3 !== 3'b000 || err3 !== 1'b1) begin
      bad++; $display("FAIL badsel_err ov=%b err=%b want 000/1", ov3, err3);
    end
    for (int i = 0; i < 3; i++) begin sel3 = 2'(i); dat3 = 8'(8'h70 + i); tick(); end
    sel3 = 2'd3; #1;
    total++; if (ir3 !== 1'b1) begin bad++; $display("FAIL badsel_full got=%b want=1", ir3); end
    iv3 = 0; tick(); tick();
    total++; if (ov3 !== 3'b111 || od3 !== 24'h727170 || err3 !== 1'b1) begin
      bad++; $display("FAIL badsel_sticky ov=%b od=%h err=%b want 111/727170/1", ov3, od3, err3);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if (err3 !== 1'b0 || ov3 !== 3'b000) begin
      bad++; $display("FAIL badsel_clear err=%b ov=%b want 0/000", err3, ov3);
    end
  endtask

`ifdef D_MUX_BCAST_EN
  task automatic test_bcast();
    ordy4 = 4'b0000;
    bc = 0; drive4(1, 0, 8'h10); tick();
    bc = 1; drive4(1, 2, 8'hC3); #1;
    total++; if (ir4 !== 1'b0) begin bad++; $display("FAIL bcast_stall got=%b want=0", ir4); end
    tick();
    total++; if (ov4 !== 4'b0001 || od4[7:0] !== 8'h10) begin
      bad++; $display("FAIL bcast_hold ov=%b d0=%h want 0001/10", ov4, od4[7:0]);
    end
    ordy4 = 4'b0001; #1;
    total++; if (ir4 !== 1'b1) begin bad++; $display("FAIL bcast_release got=%b want=1", ir4); end
    tick();
    total++; if (ov4 !== 4'hF || od4 !== 32'hC3C3C3C3 || err4 !== 1'b0) begin
      bad++; $display("FAIL bcast_load ov=%b od=%h err=%b want f/c3c3c3c3/0", ov4, od4, err4);
    end
    bc = 0; drive4(0, 0, 0); ordy4 = 4'hF; tick();
  endtask
`endif

  initial begin
    mv = '0; merr = 1'b0;
    for (int i = 0; i < 4; i++) md[i] = 8'h00;
    test_reset();
    test_steering();
    test_backpressure();
    test_isolation();
    test_random();
`ifdef D_MUX_BCAST_EN
    test_bcast();
`endif
    test_bad_sel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
